// File: rtl/card_shoe_dealer_if.sv
// Request/deal bus between the game FSM and the card shoe dealer.
// cards_left width follows NUM_DECKS, so the interface and dealer must share it.
interface card_shoe_dealer_if #(
  parameter int NUM_DECKS = 1
);
  localparam int RW = $clog2(52 * NUM_DECKS + 1);

  // deal_req is sampled only while deal_ready is high (IDLE).
  // Exactly one of deal_valid / deal_err pulses for one cycle per accepted request.
  // An accepted request can be dropped silently by shuffle or reset.
  logic          seed_load;
  logic [31:0]   seed;
  logic          shuffle;
  logic          deal_req;
  logic          deal_ready;
  logic          deal_valid;
  logic          deal_err;
  logic [5:0]    card_idx;
  logic [3:0]    rank;
  logic [1:0]    suit;
  logic [RW-1:0] cards_left;
  logic          shoe_empty;
  logic [1:0]    dbg_state;

  modport master (
    output seed_load, seed, shuffle, deal_req,
    input  deal_ready, deal_valid, deal_err, card_idx, rank, suit,
           cards_left, shoe_empty, dbg_state
  );

  modport slave (
    input  seed_load, seed, shuffle, deal_req,
    output deal_ready, deal_valid, deal_err, card_idx, rank, suit,
           cards_left, shoe_empty, dbg_state
  );
endinterface

// File: rtl/card_shoe_dealer.sv
// Multi-deck card shoe dealing without replacement from an xorshift32 RNG.
// Optional RNG_FREERUN_EN: the RNG advances every cycle instead of only in DRAW.
module card_shoe_dealer #(
  parameter int          NUM_DECKS    = 1,
  parameter int          MAX_RETRY    = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'd1
) (
  input logic              clk,
  input logic              reset,
  card_shoe_dealer_if.slave bus
);
  localparam int RW  = $clog2(52 * NUM_DECKS + 1);
  localparam int CW  = $clog2(NUM_DECKS + 1);
  localparam int RTW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] FULL = RW'(52 * NUM_DECKS);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PROBE} state_e;

  state_e         state_q, state_d;
  logic [31:0]    rng_q, rng_d, rng_next;
  logic [RTW-1:0] retry_q, retry_d;
  logic [5:0]     probe_q, probe_d;
  logic [CW-1:0]  cnt_q [52];
  logic [RW-1:0]  left_q;
  logic [5:0]     idx_q;
  logic [3:0]     rank_q;
  logic [1:0]     suit_q;
  logic           valid_q, err_q, err_d;
  logic           take;
  logic [5:0]     take_idx;
  logic [5:0]     cand;
  logic [51:0]    avail;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [1:0] suit_of(input logic [5:0] i);
    if (i < 6'd13)      return 2'd0;
    else if (i < 6'd26) return 2'd1;
    else if (i < 6'd39) return 2'd2;
    else                return 2'd3;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] i);
    logic [5:0] r;
    r = i - 6'd13 * {4'b0, suit_of(i)};
    return 4'(r + 6'd1);
  endfunction

  assign rng_next = xorshift32(rng_q);
  assign cand     = 6'(rng_next % 32'd52);

  always_comb begin
    avail = '0;
    for (int i = 0; i < 52; i++) avail[i] = (cnt_q[i] < CW'(NUM_DECKS));
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    probe_d  = probe_q;
    rng_d    = rng_q;
    take     = 1'b0;
    take_idx = idx_q;
    err_d    = 1'b0;
`ifdef RNG_FREERUN_EN
    rng_d = rng_next;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.deal_req) begin
          if (left_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_DRAW;
            retry_d = '0;
          end
        end
      end
      S_DRAW: begin
        rng_d = rng_next;
        // A concurrent seed load discards this attempt's candidate as a failed retry.
        if (!bus.seed_load && avail[cand]) begin
          take     = 1'b1;
          take_idx = cand;
          state_d  = S_IDLE;
        end else if (retry_q == RTW'(MAX_RETRY - 1)) begin
          state_d = S_PROBE;
          probe_d = (cand == 6'd51) ? 6'd0 : cand + 6'd1;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      S_PROBE: begin
        if (avail[probe_q]) begin
          take     = 1'b1;
          take_idx = probe_q;
          state_d  = S_IDLE;
        end else begin
          probe_d = (probe_q == 6'd51) ? 6'd0 : probe_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.seed_load) rng_d = (bus.seed == 32'd0) ? 32'd1 : bus.seed;
    // Shuffle wins over a take and leaves the RNG alone.
    if (bus.shuffle) begin
      state_d = S_IDLE;
      take    = 1'b0;
      err_d   = 1'b0;
      if (!bus.seed_load) rng_d = rng_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rng_q   <= SEED_DEFAULT;
      retry_q <= '0;
      probe_q <= '0;
      left_q  <= FULL;
      idx_q   <= '0;
      rank_q  <= '0;
      suit_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 52; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      retry_q <= retry_d;
      probe_q <= probe_d;
      valid_q <= take;
      err_q   <= err_d;
      if (bus.shuffle) begin
        left_q <= FULL;
        for (int i = 0; i < 52; i++) cnt_q[i] <= '0;
      end else if (take) begin
        cnt_q[take_idx] <= cnt_q[take_idx] + 1'b1;
        left_q          <= left_q - 1'b1;
        idx_q           <= take_idx;
        rank_q          <= rank_of(take_idx);
        suit_q          <= suit_of(take_idx);
      end
    end
  end

  assign bus.deal_ready = (state_q == S_IDLE);
  assign bus.deal_valid = valid_q;
  assign bus.deal_err   = err_q;
  assign bus.card_idx   = idx_q;
  assign bus.rank       = rank_q;
  assign bus.suit       = suit_q;
  assign bus.cards_left = left_q;
  assign bus.shoe_empty = (left_q == '0);
  assign bus.dbg_state  = state_q;
endmodule

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
- Sequential successor to the stateless xorshift `rng` block.
- Holds the RNG state in a register and models a multi-deck shoe with per-card usage counters.
- Deals cards without replacement over a request/valid handshake.
- Feeds the game FSM with rank/suit and the remaining-card count.

Parameters:
- NUM_DECKS, 1, number of 52-card decks in the shoe (1..8).
- MAX_RETRY, 8, random draws attempted before falling back to linear probe (>=1).
- SEED_DEFAULT, 32'd1, RNG state after reset; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  load seed into RNG state this cycle.
- seed  in  32  seed value; 0 is replaced by 1.
- shuffle  in  1  restore full shoe.
- deal_req  in  1  request one card; sampled only in IDLE.
- deal_ready  out  1  high in IDLE.
- deal_valid  out  1  one-cycle pulse, card outputs valid.
- deal_err  out  1  one-cycle pulse, request made while shoe empty.
- card_idx  out  6  dealt card 0..51.
- rank  out  4  (card_idx % 13) + 1.
- suit  out  2  card_idx / 13.
- cards_left  out  RW  cards remaining; RW = $clog2(52*NUM_DECKS+1).
- shoe_empty  out  1  cards_left == 0.

Behaviour:
- RNG step: xorshift32, x ^= x<<13; x ^= x>>17; x ^= x<<5. Arithmetic is 32-bit unsigned.
- Candidate index: next % 52.
- Counters: 52 per-card counters, width $clog2(NUM_DECKS+1). Card i is available iff count[i] < NUM_DECKS.
- Reset:
  - RNG state = SEED_DEFAULT; counters = 0; cards_left = 52*NUM_DECKS.
  - card_idx, rank, suit = 0; deal_valid = 0; deal_err = 0; state IDLE.
- FSM states: IDLE, DRAW, PROBE.
- IDLE:
  - deal_req && shoe_empty: pulse deal_err next cycle; stay IDLE.
  - deal_req && !shoe_empty: go to DRAW; retry = 0.
- DRAW, one attempt per cycle:
  - state <= xorshift(state); idx = xorshift(state) % 52.
  - If idx is available: take it and return to IDLE.
  - Else if retry == MAX_RETRY-1: go to PROBE with p = (idx+1) % 52.
  - Else: retry++.
- PROBE, one index per cycle:
  - If p is available: take it and return to IDLE.
  - Else: p = (p+1) % 52, wrapping 51 -> 0.
  - Terminates within 52 cycles because the shoe is non-empty.
- Take, all in the same cycle:
  - count[i]++; cards_left--.
  - card_idx/rank/suit registered; deal_valid pulses the following cycle.
  - Best-case latency: deal_req sampled at edge t, deal_valid high in cycle t+2.
- Outputs hold the last dealt card until the next take.
- RNG advances only in DRAW.
- seed_load:
  - Any state: RNG state <= (seed == 0 ? 1 : seed). Does not abort a deal in progress.
  - Seed takes effect from the next DRAW attempt.
  - seed_load and a DRAW step in the same cycle: seed_load wins, and that attempt's candidate is discarded (counts as a retry).
- shuffle:
  - Clears all counters; cards_left = 52*NUM_DECKS.
  - Aborts DRAW/PROBE back to IDLE; no deal_valid for the aborted request.
  - shuffle and a take in the same cycle: shuffle wins and no card is dealt.
  - shuffle does not touch RNG state.
- reset mid-operation: returns to the full reset state; no pulse is emitted.
- deal_req outside IDLE is ignored; the requester must wait for deal_ready.

Optional Feature:
- Macro: RNG_FREERUN_EN.
- Defined:
  - RNG state advances every cycle in every state, giving entropy from player timing.
  - DRAW uses the advanced value as usual.
  - seed_load still overrides.
- Undefined:
  - RNG advances only in DRAW, so the deal sequence is a pure function of seed and request count.
- All Test Plan values assume the macro is undefined.

Test Plan:
- Reset, NUM_DECKS=1, then deal_req: card_idx=21, rank=9, suit=1, deal_valid at cycle t+2, cards_left=51. Derivation: seed 1 -> next 270369 -> 270369 % 52 = 21.
- seed_load seed=0, then deal_req: identical outputs to the reset case (seed 0 mapped to 1).
- Deal 52 cards with NUM_DECKS=1: all card_idx values distinct, covering 0..51; cards_left=0; shoe_empty=1. A 53rd deal_req gives a deal_err pulse and no deal_valid.
- Near-empty shoe, MAX_RETRY=1: fill 51 counters leaving only card 0, then deal_req. PROBE wraps past 51 and deals card_idx=0 within 53 cycles of the request.
- shuffle asserted in the cycle after deal_req is accepted: no deal_valid; cards_left restored to 52*NUM_DECKS; deal_ready high the next cycle.
- NUM_DECKS=2: 104 deals succeed; each card_idx appears exactly twice; then shoe_empty=1.
